l0_skew_buffer: RTL

//   Parametrised L0 input buffer: ROW independent per-row FIFOs, written in parallel and read either all rows at once or staggered.

---
 rtl/l0_skew_buffer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/l0_skew_buffer.sv
// L0 input buffer: ROW parallel-written row FIFOs, read all at once or with per-row diagonal skew.
// Define L0_ERR_EN to add the sticky o_err[1:0] port (dropped write / empty-row read).
module l0_skew_buffer #(
  parameter int unsigned ROW   = 8,
  parameter int unsigned BW    = 4,
  parameter int unsigned DEPTH = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [ROW*BW-1:0] in,
  input  logic              rd,
  input  logic              mode,
  output logic [ROW*BW-1:0] out,
  output logic [ROW-1:0]    o_valid,
  output logic              o_full,
  output logic              o_ready,
  output logic              o_empty,
`ifdef L0_ERR_EN
  output logic [1:0]        o_err,
`endif
  output logic              o_busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);

  logic [BW-1:0] mem_q [ROW][DEPTH];
  logic [BW-1:0] mem_d [ROW][DEPTH];
  logic [AW-1:0] wr_ptr_q [ROW];
  logic [AW-1:0] wr_ptr_d [ROW];
  logic [AW-1:0] rd_ptr_q [ROW];
  logic [AW-1:0] rd_ptr_d [ROW];
  logic [AW:0]   count_q [ROW];
  logic [AW:0]   count_d [ROW];

  logic [ROW-1:0]    rd_pipe_q, rd_pipe_d;
  logic [ROW-1:0]    valid_q, valid_d;
  logic [ROW*BW-1:0] out_q, out_d;
  logic              mode_q, mode_d;

  logic [ROW-1:0] row_full, row_empty, pop;
  logic           push;

  always_comb begin
    for (int i = 0; i < ROW; i++) begin
      row_full[i]  = (count_q[i] == FullCnt);
      row_empty[i] = (count_q[i] == '0);
    end
  end

  assign o_full  = |row_full;
  assign o_ready = ~o_full;
  assign o_empty = &row_empty;
  assign o_busy  = |rd_pipe_q;
  assign out     = out_q;
  assign o_valid = valid_q;

  // Fullness comes from registered counts, so a same-cycle pop never frees a slot for a push.
  assign push = wr & o_ready;
  assign pop  = rd_pipe_q & ~row_empty;

  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < ROW; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      count_d[i]  = count_q[i];
      if (push) begin
        mem_d[i][wr_ptr_q[i]] = in[i*BW +: BW];
        wr_ptr_d[i] = wr_ptr_q[i] + AW'(1);
      end
      if (pop[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + AW'(1);
      end
      unique case ({push, pop[i]})
        2'b10:   count_d[i] = count_q[i] + (AW+1)'(1);
        2'b01:   count_d[i] = count_q[i] - (AW+1)'(1);
        default: count_d[i] = count_q[i];
      endcase
    end
  end

  always_comb begin
    out_d   = out_q;
    valid_d = pop;
    for (int i = 0; i < ROW; i++) begin
      if (pop[i]) begin
        out_d[i*BW +: BW] = mem_q[i][rd_ptr_q[i]];
      end
    end
  end

  // Staggered mode shifts the read request one row per cycle; mode only switches when idle.
  always_comb begin
    if (mode_q) begin
      rd_pipe_d = {rd_pipe_q[ROW-2:0], rd};
    end else begin
      rd_pipe_d = {ROW{rd}};
    end
    mode_d = mode_q;
    if ((rd_pipe_q == '0) && !rd) begin
      mode_d = mode;
    end
  end

`ifdef L0_ERR_EN
  logic [1:0] err_q, err_d;

  always_comb begin
    err_d    = err_q;
    err_d[0] = err_q[0] | (wr & o_full);
    err_d[1] = err_q[1] | (|(rd_pipe_q & row_empty));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign o_err = err_q;
`endif

  // Storage needs no reset: counts gate every read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ROW; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      rd_pipe_q <= '0;
      valid_q   <= '0;
      out_q     <= '0;
      mode_q    <= 1'b0;
    end else begin
      for (int i = 0; i < ROW; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        count_q[i]  <= count_d[i];
      end
      rd_pipe_q <= rd_pipe_d;
      valid_q   <= valid_d;
      out_q     <= out_d;
      mode_q    <= mode_d;
    end
  end

endmodule
